button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable synchronized samples needed to accept a level change (10 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter REPEAT_DELAY, default 50000000, is the number of cycles from the first INC pulse to the first auto-repeat pulse; legal range >= 2.
REQ-003 Parameter REPEAT_PERIOD, default 10000000, is the number of cycles between successive auto-repeat pulses; legal range >= 2.
REQ-004 CLK_100M  input  1  single system clock; all logic rises on its positive edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 BTN_RAW  input  3  raw asynchronous buttons; bit0 START, bit1 STOP, bit2 INC; active-high, may bounce.
REQ-007 BTN_LEVEL  output  3  debounced, synchronized button levels, same bit order as BTN_RAW.
REQ-008 START_PULSE  output  1  one-cycle pulse per accepted START press.
REQ-009 STOP_PULSE  output  1  one-cycle pulse per accepted STOP press.
REQ-010 INC_PULSE  output  1  one-cycle pulse per accepted INC press plus auto-repeat pulses while INC is held.

Function
REQ-011 Each BTN_RAW bit shall pass through a 2-flop synchronizer before any other use.
REQ-012 Each channel shall keep a stable level and a debounce counter.
REQ-013 Debounce counter behaviour per cycle:
- synchronized value != stable level: counter increments.
- synchronized value == stable level: counter clears to 0.
REQ-014 The stable level shall take the synchronized value on the edge where the counter equals DEBOUNCE_CYCLES-1 and the values still differ; the counter shall clear on that same edge.
REQ-015 BTN_LEVEL shall equal the stable levels directly, with no extra register.
REQ-016 A 0->1 transition of a stable level shall produce a registered pulse exactly one cycle wide; a 1->0 transition shall produce no pulse.
REQ-017 Latency for clean input: if edge N is the first edge that samples a new raw level, the stable level shall change at edge N+DEBOUNCE_CYCLES+1 and the pulse shall assert at edge N+DEBOUNCE_CYCLES+2.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall change neither BTN_LEVEL nor any pulse output.
REQ-019 Simultaneous START and STOP pulses in the same cycle: STOP_PULSE shall assert and START_PULSE shall be suppressed.
REQ-020 The INC auto-repeat FSM shall have states IDLE, DELAY and REPEAT, plus a repeat counter sized for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-021 IDLE -> DELAY on a rising edge of the INC stable level, which also emits INC_PULSE and clears the counter.
REQ-022 In DELAY, when the counter reaches REPEAT_DELAY-1: emit INC_PULSE, clear the counter, move to REPEAT.
REQ-023 In REPEAT, every time the counter reaches REPEAT_PERIOD-1: emit INC_PULSE, clear the counter, stay in REPEAT.
REQ-024 A falling edge of the INC stable level in DELAY or REPEAT shall go to IDLE on the next edge with no pulse; this overrides a coincident repeat tick.
REQ-025 The repeat counter shall never wrap; it clears at every state transition and at every emitted pulse.
REQ-026 START and STOP shall have no auto-repeat; holding them yields exactly one pulse per press.

Reset
REQ-027 While RST_N=0, all of the following shall be 0, the FSM shall be IDLE, and all counters shall be 0:
- synchronizer flops
- stable levels, BTN_LEVEL
- START_PULSE, STOP_PULSE, INC_PULSE
REQ-028 Reset asserted mid-operation shall abort debounce and auto-repeat immediately, with no pulse emitted.
REQ-029 A button held through reset release shall be treated as a new press: one pulse, DEBOUNCE_CYCLES+2 edges after the first post-reset sampling edge.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-030 Assert RST_N=0 with BTN_RAW=3'b111 -> all outputs 0 throughout reset.
REQ-031 Clean START high for 12 cycles, sampled first at edge N -> BTN_LEVEL[0] rises at N+5, START_PULSE high only at N+6; release gives no pulse.
REQ-032 INC bounce: toggles every 2 cycles for 12 cycles, then held high -> exactly one INC_PULSE, 6 edges after the last transition is sampled.
REQ-033 INC held 70 cycles past the first pulse at edge T -> INC_PULSE at T, T+20, T+28, T+36, T+44, T+52, T+60, T+68, and nothing else; release -> FSM returns to IDLE.
REQ-034 START and STOP rise on the same edge -> STOP_PULSE once, START_PULSE never.
REQ-035 RST_N pulsed low at T+25 while INC is held -> pulses stop immediately; after release, a fresh INC_PULSE appears 6 edges later and the repeat schedule restarts from it.

Source files
------------

// File: rtl/button_conditioner_if.sv
// button_conditioner_if
//   Groups the button-side signals of the conditioner into one bundle.
//   BTN_RAW      3  raw asynchronous buttons (bit0 START, bit1 STOP, bit2 INC)
//   BTN_LEVEL    3  debounced, synchronized levels, same bit order
//   START_PULSE  1  one-cycle pulse per accepted START press
//   STOP_PULSE   1  one-cycle pulse per accepted STOP press
//   INC_PULSE    1  one-cycle pulse per INC press plus auto-repeat pulses
//   master : the conditioner (consumes BTN_RAW, drives everything else)
//   slave  : the user of the conditioned buttons (drives BTN_RAW)
interface button_conditioner_if;
  logic [2:0] BTN_RAW;
  logic [2:0] BTN_LEVEL;
  logic       START_PULSE;
  logic       STOP_PULSE;
  logic       INC_PULSE;

  modport master (
    input  BTN_RAW,
    output BTN_LEVEL,
    output START_PULSE,
    output STOP_PULSE,
    output INC_PULSE
  );

  modport slave (
    output BTN_RAW,
    input  BTN_LEVEL,
    input  START_PULSE,
    input  STOP_PULSE,
    input  INC_PULSE
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner
//   Synchronizes and debounces three push buttons (START, STOP, INC), turns
//   accepted presses into one-cycle pulses and auto-repeats INC while held.
//   Ports:
//     CLK_100M  in   system clock, everything runs on its rising edge
//     RST_N     in   asynchronous active-low reset
//     btn       bus  button_conditioner_if.master (raw buttons in, levels and
//                    pulses out)
//   Parameters:
//     DEBOUNCE_CYCLES  stable synchronized samples needed to accept a change
//     REPEAT_DELAY     cycles from the first INC pulse to the first repeat
//     REPEAT_PERIOD    cycles between successive repeat pulses
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic                        CLK_100M,
  input  logic                        RST_N,
  button_conditioner_if.master        btn
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  localparam int CH_START = 0;
  localparam int CH_STOP  = 1;
  localparam int CH_INC   = 2;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer on every raw button
  // ---------------------------------------------------------------------
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      sync1_reg <= 3'b000;
      sync2_reg <= 3'b000;
    end else begin
      sync1_reg <= btn.BTN_RAW;
      sync2_reg <= sync1_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel debounce: the counter runs only while the synchronized value
  // disagrees with the accepted level, so any agreeing sample restarts it.
  // ---------------------------------------------------------------------
  logic [2:0] stable_level;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_debounce
      logic            stable_reg;
      logic [DB_W-1:0] db_cnt_reg;

      always_ff @(posedge CLK_100M or negedge RST_N) begin
        if (!RST_N) begin
          stable_reg <= 1'b0;
          db_cnt_reg <= '0;
        end else if (sync2_reg[gi] != stable_reg) begin
          if (db_cnt_reg == DB_LAST) begin
            stable_reg <= sync2_reg[gi];
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end else begin
          db_cnt_reg <= '0;
        end
      end

      assign stable_level[gi] = stable_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Edge detection on the accepted levels
  // ---------------------------------------------------------------------
  logic [2:0] stable_d_reg;
  logic [2:0] level_rise;
  logic [2:0] level_fall;

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      stable_d_reg <= 3'b000;
    end else begin
      stable_d_reg <= stable_level;
    end
  end

  assign level_rise = stable_level & ~stable_d_reg;
  assign level_fall = ~stable_level & stable_d_reg;

  // START and STOP: single pulse per press. STOP wins a same-cycle tie so a
  // controller never sees both commands at once.
  logic start_pulse_reg;
  logic stop_pulse_reg;

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      start_pulse_reg <= 1'b0;
      stop_pulse_reg  <= 1'b0;
    end else begin
      start_pulse_reg <= level_rise[CH_START] & ~level_rise[CH_STOP];
      stop_pulse_reg  <= level_rise[CH_STOP];
    end
  end

  // ---------------------------------------------------------------------
  // INC auto-repeat FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [RPT_W-1:0] rpt_cnt_reg;
  logic [RPT_W-1:0] rpt_cnt_next;
  logic             inc_pulse_reg;
  logic             inc_pulse_next;

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= ST_IDLE;
      rpt_cnt_reg   <= '0;
      inc_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rpt_cnt_reg   <= rpt_cnt_next;
      inc_pulse_reg <= inc_pulse_next;
    end
  end

  // A release always takes priority over a repeat tick landing on the same
  // cycle, so letting go never produces a trailing pulse.
  always_comb begin
    state_next     = state_reg;
    rpt_cnt_next   = rpt_cnt_reg + 1'b1;
    inc_pulse_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        rpt_cnt_next = '0;
        if (level_rise[CH_INC]) begin
          state_next     = ST_DELAY;
          inc_pulse_next = 1'b1;
        end
      end
      ST_DELAY: begin
        if (level_fall[CH_INC]) begin
          state_next   = ST_IDLE;
          rpt_cnt_next = '0;
        end else if (rpt_cnt_reg == DELAY_LAST) begin
          state_next     = ST_REPEAT;
          rpt_cnt_next   = '0;
          inc_pulse_next = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (level_fall[CH_INC]) begin
          state_next   = ST_IDLE;
          rpt_cnt_next = '0;
        end else if (rpt_cnt_reg == PERIOD_LAST) begin
          rpt_cnt_next   = '0;
          inc_pulse_next = 1'b1;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        rpt_cnt_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign btn.BTN_LEVEL   = stable_level;
  assign btn.START_PULSE = start_pulse_reg;
  assign btn.STOP_PULSE  = stop_pulse_reg;
  assign btn.INC_PULSE   = inc_pulse_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
//   Directed bench for button_conditioner with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=20, REPEAT_PERIOD=8. A per-cycle vector table covers reset,
//   a clean START press/release and a simultaneous START+STOP press; hand
//   sequences cover INC bounce, the auto-repeat schedule with a release that
//   coincides with a repeat tick, and a reset in the middle of auto-repeat.
//   Inputs change on the falling edge; outputs are checked on the falling
//   edge after each rising edge.
module tb_button_conditioner;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  button_conditioner_if bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .CLK_100M(clk),
    .RST_N   (rst_n),
    .btn     (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [2:0] raw;
    logic [2:0] level;
    logic       start;
    logic       stop;
    logic       inc;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input logic r, input logic [2:0] raw, input logic [2:0] lvl,
                              input logic st, input logic sp, input logic inc, input int reps);
    vec_t v;
    v.rst_n = r;
    v.raw   = raw;
    v.level = lvl;
    v.start = st;
    v.stop  = sp;
    v.inc   = inc;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endfunction

  // Drive inputs, let one rising edge sample them, land on the falling edge.
  task automatic tick(input logic r, input logic [2:0] raw);
    rst_n       = r;
    bif.BTN_RAW = raw;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int idx, input logic [5:0] exp);
    logic [5:0] got;
    got = {bif.BTN_LEVEL, bif.START_PULSE, bif.STOP_PULSE, bif.INC_PULSE};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got lvl/st/sp/inc=%b required=%b", name, idx, got, exp);
    end else begin
      $display("ok   %s[%0d] lvl/st/sp/inc=%b", name, idx, got);
    end
  endtask

  function automatic logic in_list(input int c, input int lst[$]);
    foreach (lst[k]) if (lst[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_count(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end else begin
      $display("ok   %s count=%0d", name, got);
    end
  endtask

  initial begin
    int         inc_edges[$];
    int         n_inc;
    logic       r;
    logic [2:0] raw;
    logic [2:0] lvl;
    logic       inc;

    rst_n       = 1'b0;
    bif.BTN_RAW = 3'b111;

    // ---- table: reset, clean START, START+STOP tie ----
    add(1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 4);  // held in reset, buttons pressed
    add(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3);
    add(1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 5);  // START first sampled at idx 7
    add(1'b1, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 1);  // level at N+5
    add(1'b1, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1);  // pulse at N+6
    add(1'b1, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 5);  // held, no repeat
    add(1'b1, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 5);  // release sampled at idx 19
    add(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3);  // falls, no pulse
    add(1'b1, 3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 5);  // START+STOP sampled at idx 27
    add(1'b1, 3'b011, 3'b011, 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 3'b011, 3'b011, 1'b0, 1'b1, 1'b0, 1);  // STOP only
    add(1'b1, 3'b011, 3'b011, 1'b0, 1'b0, 1'b0, 3);
    add(1'b1, 3'b000, 3'b011, 1'b0, 1'b0, 1'b0, 5);
    add(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].rst_n, vecs[i].raw);
      check("table", i, {vecs[i].level, vecs[i].start, vecs[i].stop, vecs[i].inc});
    end

    // ---- INC bounce: H H L L ... for 12 cycles, held from c=12, released at c=31 ----
    n_inc = 0;
    for (int c = 0; c <= 45; c++) begin
      if (c < 12) raw = ((c / 2) % 2 == 0) ? 3'b100 : 3'b000;
      else        raw = (c <= 30) ? 3'b100 : 3'b000;
      tick(1'b1, raw);
      lvl = (c >= 17 && c <= 35) ? 3'b100 : 3'b000;
      inc = (c == 18);
      if (bif.INC_PULSE === 1'b1) n_inc++;
      check("bounce", c, {lvl, 1'b0, 1'b0, inc});
    end
    check_count("bounce_inc_pulses", n_inc, 1);

    // ---- INC auto-repeat; release lands on the T+76 repeat tick ----
    inc_edges = '{6, 26, 34, 42, 50, 58, 66, 74};
    n_inc = 0;
    for (int c = 0; c <= 95; c++) begin
      tick(1'b1, (c <= 75) ? 3'b100 : 3'b000);
      lvl = (c >= 5 && c <= 80) ? 3'b100 : 3'b000;
      inc = in_list(c, inc_edges);
      if (bif.INC_PULSE === 1'b1) n_inc++;
      check("repeat", c, {lvl, 1'b0, 1'b0, inc});
    end
    check_count("repeat_inc_pulses", n_inc, 8);

    // ---- reset during auto-repeat, INC held through it ----
    inc_edges = '{6, 26, 40, 60, 68, 76, 84};
    n_inc = 0;
    for (int c = 0; c <= 95; c++) begin
      r = !(c >= 31 && c <= 33);
      tick(r, (c <= 80) ? 3'b100 : 3'b000);
      lvl = ((c >= 5 && c <= 30) || (c >= 39 && c <= 85)) ? 3'b100 : 3'b000;
      inc = in_list(c, inc_edges);
      if (bif.INC_PULSE === 1'b1) n_inc++;
      check("rst_mid", c, {lvl, 1'b0, 1'b0, inc});
    end
    check_count("rst_mid_inc_pulses", n_inc, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
